// File: rtl/warp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | warp_pkg                                                             |
// | Shared types for the warp engine RoCC front end.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package warp_pkg;

    localparam int XLEN      = 64;
    localparam int TAG_WIDTH = 16;

    typedef enum logic [6:0] {
        LAUNCH     = 7'd0,
        SET_MASK   = 7'd1,
        SET_BASE   = 7'd2,
        GET_STATUS = 7'd3,
        FENCE      = 7'd4,
        CLEAR_ERR  = 7'd5
    } warp_funct_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESP       = 2'd1,
        FENCE_WAIT = 2'd2
    } fe_state_e;

    typedef struct packed {
        logic [2:0]      op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } warp_instr_t;

endpackage
`default_nettype wire

// File: rtl/rocc_funct_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rocc_funct_decode                                                    |
// | Classifies a RoCC funct7 into enqueue / local / illegal.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rocc_funct_decode
    import warp_pkg::*;
(
    input  logic [6:0] funct,
    output logic       is_enq,
    output logic       is_local,
    output logic       is_illegal,
    output logic [2:0] op
);

    always_comb begin
        is_enq     = 1'b0;
        is_local   = 1'b0;
        is_illegal = 1'b0;
        op         = funct[2:0];
        case (funct)
            LAUNCH, SET_MASK, SET_BASE:    is_enq     = 1'b1;
            GET_STATUS, FENCE, CLEAR_ERR:  is_local   = 1'b1;
            default:                       is_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rocc_cmd_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rocc_cmd_frontend                                                    |
// | RoCC command/response front end feeding the warp instruction FIFO.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rocc_cmd_frontend #(
    parameter int XLEN         = 64,
    parameter int TAG_WIDTH    = 16,
    parameter int STATUS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [6:0]            cmd_funct,
    input  logic [XLEN-1:0]       cmd_rs1,
    input  logic [XLEN-1:0]       cmd_rs2,
    input  logic [4:0]            cmd_rd,
    input  logic                  cmd_xd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [4:0]            resp_rd,
    output logic [XLEN-1:0]       resp_data,
    output logic                  fifo_push,
    output logic [3+2*XLEN-1:0]   fifo_data,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    input  logic                  engine_idle,
    input  logic [STATUS_WIDTH-1:0] engine_status,
    output logic                  busy,
    output logic                  interrupt
);

    import warp_pkg::*;

    fe_state_e              r_state;
    fe_state_e              w_state_next;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_err;
    logic                   r_fence_xd;
    logic [4:0]             r_resp_rd;
    logic [XLEN-1:0]        r_resp_data;
    logic                   r_fifo_push;
    logic [3+2*XLEN-1:0]    r_fifo_data;

    logic                   w_is_enq;
    logic                   w_is_local;
    logic                   w_is_illegal;
    logic [2:0]             w_op;
    logic                   w_accept;
    logic                   w_drained;
    logic [XLEN-1:0]        w_status_word;
    logic [XLEN-1:0]        w_resp_data;

    rocc_funct_decode u_decode (
        .funct      (cmd_funct),
        .is_enq     (w_is_enq),
        .is_local   (w_is_local),
        .is_illegal (w_is_illegal),
        .op         (w_op)
    );

    // Held low through reset so the host never sees a ready during reset.
    assign cmd_ready  = rst_n && (r_state == IDLE) && !fifo_full;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_drained  = engine_idle && fifo_empty && !r_fifo_push;

    assign resp_valid = (r_state == RESP);
    assign resp_rd    = r_resp_rd;
    assign resp_data  = r_resp_data;
    assign fifo_push  = r_fifo_push;
    assign fifo_data  = r_fifo_data;
    assign interrupt  = r_err;
    assign busy       = (r_state != IDLE) || r_fifo_push || !fifo_empty || !engine_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_local && (cmd_funct == FENCE)) begin
                        w_state_next = FENCE_WAIT;
                    end else if (cmd_xd) begin
                        w_state_next = RESP;
                    end
                end
            end
            FENCE_WAIT: begin
                if (w_drained) begin
                    w_state_next = r_fence_xd ? RESP : IDLE;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_status_word           = XLEN'(engine_status);
        w_status_word[XLEN-1]   = r_err;
        w_resp_data             = '0;
        if (w_is_enq) begin
            w_resp_data = XLEN'(r_tag);
        end else if (w_is_illegal) begin
            w_resp_data = '1;
        end else begin
            case (cmd_funct)
                GET_STATUS: w_resp_data = w_status_word;
                CLEAR_ERR:  w_resp_data = XLEN'(r_err);
                default:    w_resp_data = '0;
            endcase
        end
    end

    // Response fields are only captured on accept, so they stay frozen in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag       <= '0;
            r_err       <= 1'b0;
            r_fence_xd  <= 1'b0;
            r_resp_rd   <= '0;
            r_resp_data <= '0;
            r_fifo_push <= 1'b0;
            r_fifo_data <= '0;
        end else begin
            r_fifo_push <= w_accept && w_is_enq;
            if (w_accept) begin
                r_resp_rd   <= cmd_rd;
                r_resp_data <= w_resp_data;
                r_fence_xd  <= cmd_xd;
                if (w_is_enq) begin
                    r_tag       <= r_tag + TAG_WIDTH'(1);
                    r_fifo_data <= {w_op, cmd_rs1, cmd_rs2};
                end
                if (w_is_illegal) begin
                    r_err <= 1'b1;
                end else if (w_is_local && (cmd_funct == CLEAR_ERR)) begin
                    r_err <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rocc_cmd_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rocc_cmd_frontend                                                 |
// | Directed self-checking bench for rocc_cmd_frontend.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rocc_cmd_frontend;

    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [6:0]        cmd_funct;
    logic [XLEN-1:0]   cmd_rs1;
    logic [XLEN-1:0]   cmd_rs2;
    logic [4:0]        cmd_rd;
    logic              cmd_xd;
    logic              resp_valid;
    logic              resp_ready;
    logic [4:0]        resp_rd;
    logic [XLEN-1:0]   resp_data;
    logic              fifo_push;
    logic [3+2*XLEN-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              engine_idle;
    logic [31:0]       engine_status;
    logic              busy;
    logic              interrupt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rocc_cmd_frontend dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_funct     (cmd_funct),
        .cmd_rs1       (cmd_rs1),
        .cmd_rs2       (cmd_rs2),
        .cmd_rd        (cmd_rd),
        .cmd_xd        (cmd_xd),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rd       (resp_rd),
        .resp_data     (resp_data),
        .fifo_push     (fifo_push),
        .fifo_data     (fifo_data),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .engine_idle   (engine_idle),
        .engine_status (engine_status),
        .busy          (busy),
        .interrupt     (interrupt)
    );

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        logic        pat [6];
        logic [63:0] v1;
        logic [63:0] v2;
        int          k;
        int          pushes;
        int          exp_tag;
        int          n;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_funct = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_rd = '0; cmd_xd = 1'b0; resp_ready = 1'b0; fifo_full = 1'b0;
        fifo_empty = 1'b1; engine_idle = 1'b1; engine_status = '0;
        exp_tag = 0;

        // Reset state
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_fifo_push", fifo_push, 0);
        chk("rst_fifo_data", fifo_data, 0);
        chk("rst_interrupt", interrupt, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);

        // LAUNCH with response
        cmd_valid = 1'b1; cmd_funct = 7'd0; cmd_rs1 = 64'h1000; cmd_rs2 = 64'h20;
        cmd_rd = 5'd5; cmd_xd = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("launch_push", fifo_push, 1);
        chk("launch_data", fifo_data, {3'd0, 64'h1000, 64'h20});
        chk("launch_resp_valid", resp_valid, 1);
        chk("launch_resp_rd", resp_rd, 5);
        chk("launch_resp_data", resp_data, 0);
        chk("launch_busy", busy, 1);
        chk("launch_ready_in_resp", cmd_ready, 0);
        handshake();
        exp_tag = 1;
        chk("launch_push_one_cycle", fifo_push, 0);
        chk("launch_resp_done", resp_valid, 0);
        chk("launch_ready_after", cmd_ready, 1);

        // Three SET_BASE, no response, fifo_full toggling
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        k = 0; pushes = 0;
        cmd_valid = 1'b1; cmd_funct = 7'd2; cmd_xd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v1 = 64'h100 + 64'(k);
            v2 = 64'h200 + 64'(k);
            fifo_full = pat[i]; cmd_rs1 = v1; cmd_rs2 = v2;
            #1;
            chk("setbase_ready_vs_full", cmd_ready, !pat[i]);
            step();
            chk("setbase_push", fifo_push, !pat[i]);
            if (fifo_push) begin
                pushes++;
                chk("setbase_data", fifo_data, {3'd2, v1, v2});
            end
            if (!pat[i]) k++;
            chk("setbase_no_resp", resp_valid, 0);
        end
        cmd_valid = 1'b0; fifo_full = 1'b0;
        step();
        chk("setbase_no_extra_push", fifo_push, 0);
        chk("setbase_push_count", pushes, 3);
        exp_tag = exp_tag + 3;

        // ILLEGAL without response sets the sticky error
        cmd_valid = 1'b1; cmd_funct = 7'd9; cmd_xd = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("illegal_irq", interrupt, 1);
        chk("illegal_no_push", fifo_push, 0);
        chk("illegal_no_resp", resp_valid, 0);

        // GET_STATUS with err=1, response stalled
        cmd_valid = 1'b1; cmd_funct = 7'd3; cmd_xd = 1'b1; cmd_rd = 5'd7;
        engine_status = 32'hA5;
        step();
        cmd_valid = 1'b0; engine_status = 32'h5A;
        chk("status_valid", resp_valid, 1);
        chk("status_data", resp_data, 64'h8000_0000_0000_00A5);
        chk("status_rd", resp_rd, 7);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("status_hold_valid", resp_valid, 1);
            chk("status_hold_data", resp_data, 64'h8000_0000_0000_00A5);
        end
        handshake();
        chk("status_done", resp_valid, 0);
        chk("status_ready_after", cmd_ready, 1);

        // ILLEGAL with response, err already set
        cmd_valid = 1'b1; cmd_funct = 7'd9; cmd_xd = 1'b1; cmd_rd = 5'd3;
        step();
        cmd_valid = 1'b0;
        chk("illegal_resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("illegal_irq_stays", interrupt, 1);
        chk("illegal_resp_rd", resp_rd, 3);
        handshake();

        // CLEAR_ERR returns previous err
        cmd_valid = 1'b1; cmd_funct = 7'd5; cmd_xd = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("clear_resp_data", resp_data, 1);
        chk("clear_irq", interrupt, 0);
        handshake();
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("clear_again_data", resp_data, 0);
        handshake();

        // FENCE waiting on a busy engine
        cmd_valid = 1'b1; cmd_funct = 7'd4; cmd_xd = 1'b1; cmd_rd = 5'd9;
        fifo_empty = 1'b0; engine_idle = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("fence_wait_valid", resp_valid, 0);
            chk("fence_wait_busy", busy, 1);
            chk("fence_wait_ready", cmd_ready, 0);
            step();
        end
        engine_idle = 1'b1; fifo_empty = 1'b1;
        #1;
        chk("fence_not_yet", resp_valid, 0);
        step();
        chk("fence_resp_valid", resp_valid, 1);
        chk("fence_resp_data", resp_data, 0);
        chk("fence_resp_rd", resp_rd, 9);
        handshake();
        chk("fence_idle_busy", busy, 0);

        // FENCE with engine already drained, no response
        cmd_valid = 1'b1; cmd_funct = 7'd4; cmd_xd = 1'b0;
        step();
        cmd_valid = 1'b0;
        chk("fence0_busy", busy, 1);
        chk("fence0_ready", cmd_ready, 0);
        step();
        chk("fence0_exit_ready", cmd_ready, 1);
        chk("fence0_exit_busy", busy, 0);
        chk("fence0_no_resp", resp_valid, 0);

        // Tag wrap
        n = 16'hFFFF - exp_tag;
        cmd_valid = 1'b1; cmd_funct = 7'd0; cmd_xd = 1'b0;
        cmd_rs1 = 64'h1; cmd_rs2 = 64'h2;
        repeat (n) @(posedge clk);
        #1;
        cmd_xd = 1'b1; cmd_rd = 5'd1;
        step();
        cmd_valid = 1'b0;
        chk("wrap_tag_ffff", resp_data, 64'hFFFF);
        chk("wrap_valid", resp_valid, 1);
        handshake();
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("wrap_tag_zero", resp_data, 0);

        // Asynchronous reset in the middle of RESP
        rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_push", fifo_push, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_release_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_funct = 7'd1; cmd_xd = 1'b1; cmd_rd = 5'd2;
        cmd_rs1 = 64'hDEAD; cmd_rs2 = 64'hBEEF;
        step();
        cmd_valid = 1'b0;
        chk("post_rst_tag", resp_data, 0);
        chk("post_rst_fifo_data", fifo_data, {3'd1, 64'hDEAD, 64'hBEEF});
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
